dwt_level_sequencer: RTL and testbench

DWT_LEVEL_SEQUENCER -- requirements
Module: dwt_level_sequencer

---
 rtl/dwt_level_sequencer.sv | 155 +++++++++++++++
 tb/tb_dwt_level_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_level_sequencer.sv
// Level-by-level pair issue sequencer for a fixed-latency DWT core: issues pair
// indices per level, tracks in-flight tags over LAT cycles and drains between levels.
module dwt_level_sequencer #(
   parameter int N      = 8,
   parameter int LEVELS = 3,
   parameter int LAT    = 3,
   localparam int IDXW  = ((N / 2) > 1) ? $clog2(N / 2) : 1,
   localparam int LW    = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic            core_ready,
   output logic            issue_valid,
   output logic [IDXW-1:0] issue_idx,
   output logic [LW-1:0]   issue_level,
   output logic            wr_en,
   output logic [IDXW-1:0] wr_idx,
   output logic [LW-1:0]   wr_level,
   output logic            busy,
   output logic            done,
   output logic [1:0]      dbg_state
);

   localparam int CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_q;
   logic [IDXW-1:0] idx_q;
   logic [LW-1:0]   level_q;
   logic            done_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [LAT-1:0]  tag_v_q;
   logic [IDXW-1:0] tag_idx_q [LAT];
   logic [LW-1:0]   tag_lvl_q [LAT];
   logic [IDXW-1:0] last_idx;
   logic            last_level;

   // Level L holds N>>(L+1) pairs; abort masks both strobes in its own cycle.
   assign last_idx    = IDXW'((N >> (int'(level_q) + 1)) - 1);
   assign last_level  = (level_q == LW'(LEVELS - 1));
   assign issue_valid = (state_q == ISSUE) && core_ready && !abort;
   assign issue_idx   = idx_q;
   assign issue_level = level_q;
   assign wr_en       = tag_v_q[LAT-1] && !abort;
   assign wr_idx      = tag_idx_q[LAT-1];
   assign wr_level    = tag_lvl_q[LAT-1];
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign dbg_state   = state_q;

   always_comb begin
      cnt_d = cnt_q;
      if (abort) begin
         cnt_d = '0;
      end else if (issue_valid && !wr_en) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!issue_valid && wr_en) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Tag pipe shifts every cycle so each result lands exactly LAT cycles after issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            tag_idx_q[i] <= '0;
            tag_lvl_q[i] <= '0;
         end
      end else if (abort) begin
         tag_v_q <= '0;
      end else begin
         tag_v_q[0]   <= issue_valid;
         tag_idx_q[0] <= idx_q;
         tag_lvl_q[0] <= level_q;
         for (int i = 1; i < LAT; i++) begin
            tag_v_q[i]   <= tag_v_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
            tag_lvl_q[i] <= tag_lvl_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         level_q <= '0;
         done_q  <= 1'b0;
      end else if (abort) begin
         state_q <= IDLE;
         idx_q   <= '0;
         level_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= ISSUE;
                  idx_q   <= '0;
                  level_q <= '0;
               end
            end
            ISSUE: begin
               if (issue_valid) begin
                  if (idx_q == last_idx) begin
                     state_q <= DRAIN;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               // The next level may only start once every result of this one is written.
               if (cnt_q == '0) begin
                  if (last_level) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ISSUE;
                     level_q <= level_q + 1'b1;
                     idx_q   <= '0;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dwt_level_sequencer.sv
// Bench for dwt_level_sequencer: schedule model built from the level/latency rules,
// directed scenarios for ready gaps, abort, reset and start handling, plus random ready runs.
module tb_dwt_level_sequencer;

   localparam int N      = 8;
   localparam int LEVELS = 3;
   localparam int LAT    = 3;
   localparam int IDXW   = ((N / 2) > 1) ? $clog2(N / 2) : 1;
   localparam int LW     = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int H      = 200;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            abort;
   logic            core_ready;
   logic            issue_valid;
   logic [IDXW-1:0] issue_idx;
   logic [LW-1:0]   issue_level;
   logic            wr_en;
   logic [IDXW-1:0] wr_idx;
   logic [LW-1:0]   wr_level;
   logic            busy;
   logic            done;
   logic [1:0]      dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   bit rdy    [H];
   bit exp_iv [H];
   int exp_ii [H];
   int exp_il [H];
   bit exp_wv [H];
   int exp_done_cyc;
   int last_done;
   logic [LW+IDXW-1:0] exp_q [$];
   int obs_wr [$];
   int obs_iss0 [$];

   dwt_level_sequencer #(.N(N), .LEVELS(LEVELS), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .core_ready(core_ready),
      .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_level(issue_level),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_level(wr_level),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Schedule from the rules: pairs issue in order on ready cycles, each result
   // lands LAT later, the next level starts two cycles after the last write.
   task automatic build_model();
      int t;
      int last;
      for (int i = 0; i < H; i++) begin
         exp_iv[i] = 1'b0; exp_ii[i] = 0; exp_il[i] = 0; exp_wv[i] = 1'b0;
      end
      exp_q.delete();
      t = 1;
      last = 0;
      for (int l = 0; l < LEVELS; l++) begin
         for (int k = 0; k < (N >> (l + 1)); k++) begin
            while (t < H - LAT - 4 && !rdy[t]) t++;
            exp_iv[t] = 1'b1;
            exp_ii[t] = k;
            exp_il[t] = l;
            exp_wv[t + LAT] = 1'b1;
            exp_q.push_back({LW'(l), IDXW'(k)});
            last = t;
            t++;
         end
         t = last + LAT + 2;
      end
      exp_done_cyc = t;
   endtask

   task automatic run_check(input string name);
      logic [LW+IDXW-1:0] tag;
      build_model();
      obs_wr.delete();
      obs_iss0.delete();
      last_done = -1;
      for (int c = 0; c <= exp_done_cyc + 2; c++) begin
         start = (c == 0);
         abort = 1'b0;
         core_ready = rdy[c];
         @(negedge clk);
         n_checks++;
         if (issue_valid !== exp_iv[c]) begin
            n_fail++;
            $display("FAIL %s issue_valid c%0d: got %b want %b", name, c, issue_valid, exp_iv[c]);
         end
         if (exp_iv[c]) begin
            n_checks++;
            if ({issue_level, issue_idx} !== {LW'(exp_il[c]), IDXW'(exp_ii[c])}) begin
               n_fail++;
               $display("FAIL %s issue_tag c%0d: got L%0d i%0d want L%0d i%0d",
                        name, c, issue_level, issue_idx, exp_il[c], exp_ii[c]);
            end
         end
         if (issue_valid && issue_level == '0) obs_iss0.push_back(c);
         n_checks++;
         if (wr_en !== exp_wv[c]) begin
            n_fail++;
            $display("FAIL %s wr_en c%0d: got %b want %b", name, c, wr_en, exp_wv[c]);
         end
         if (wr_en === 1'b1) begin
            obs_wr.push_back(c);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s wr_extra c%0d: got L%0d i%0d want none", name, c, wr_level, wr_idx);
            end else begin
               tag = exp_q.pop_front();
               if ({wr_level, wr_idx} !== tag) begin
                  n_fail++;
                  $display("FAIL %s wr_tag c%0d: got %h want %h", name, c, {wr_level, wr_idx}, tag);
               end
            end
         end
         n_checks++;
         if (busy !== (c >= 1 && c <= exp_done_cyc)) begin
            n_fail++;
            $display("FAIL %s busy c%0d: got %b want %b", name, c, busy, (c >= 1 && c <= exp_done_cyc));
         end
         n_checks++;
         if (done !== (c == exp_done_cyc)) begin
            n_fail++;
            $display("FAIL %s done c%0d: got %b want %b", name, c, done, (c == exp_done_cyc));
         end
         if (done === 1'b1) last_done = c;
         step();
      end
      start = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s missing_writes: got %0d left want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; core_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({issue_valid, wr_en, busy, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0000", {issue_valid, wr_en, busy, done});
      end
      step();
   endtask

   task automatic test_nominal();
      for (int i = 0; i < H; i++) rdy[i] = 1'b1;
      run_check("nominal");
      n_checks++;
      if (last_done != 20) begin
         n_fail++;
         $display("FAIL nominal_done_cycle: got %0d want 20", last_done);
      end
      n_checks++;
      if (obs_wr.size() != 7 || obs_wr[4] != 12 || obs_wr[5] != 13 || obs_wr[6] != 18) begin
         n_fail++;
         $display("FAIL nominal_wr_cycles: got %p want 4 5 6 7 12 13 18", obs_wr);
      end
   endtask

   task automatic test_ready_gaps();
      for (int i = 0; i < H; i++) rdy[i] = !(i == 2 || i == 3);
      run_check("ready_gaps");
      n_checks++;
      if (obs_iss0.size() != 4 || obs_iss0[0] != 1 || obs_iss0[1] != 4 ||
          obs_iss0[2] != 5 || obs_iss0[3] != 6) begin
         n_fail++;
         $display("FAIL gaps_issue_cycles: got %p want 1 4 5 6", obs_iss0);
      end
      n_checks++;
      if (obs_wr.size() < 4 || obs_wr[0] != 4 || obs_wr[1] != 7 || obs_wr[2] != 8 || obs_wr[3] != 9) begin
         n_fail++;
         $display("FAIL gaps_wr_cycles: got %p want 4 7 8 9 ...", obs_wr);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < H; i++) rdy[i] = (i >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
         run_check("random");
         repeat ($urandom_range(0, 3)) step();
      end
   endtask

   task automatic test_abort();
      int seen;
      core_ready = 1'b1;
      seen = -1;
      for (int c = 0; c < 40; c++) begin
         start = (c == 0 || c == 5);
         abort = (c == 3);
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            n_checks++;
            if (wr_en !== 1'b0 || done !== 1'b0 || issue_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_quiet c%0d: got wr %b done %b iv %b want 0 0 0", c, wr_en, done, issue_valid);
            end
         end
         if (c == 4 || c == 5) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_idle c%0d: got busy %b want 0", c, busy);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (issue_valid !== 1'b1 || issue_idx !== '0 || issue_level !== '0) begin
               n_fail++;
               $display("FAIL abort_restart: got iv %b L%0d i%0d want 1 L0 i0", issue_valid, issue_level, issue_idx);
            end
         end
         if (done === 1'b1 && seen < 0) seen = c;
         step();
      end
      start = 1'b0; abort = 1'b0;
      n_checks++;
      if (seen != 25) begin
         n_fail++;
         $display("FAIL abort_rerun_done: got %0d want 25", seen);
      end
   endtask

   task automatic test_reset_drain();
      core_ready = 1'b1;
      abort = 1'b0;
      for (int c = 0; c < 6; c++) begin
         start = (c == 0);
         step();
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({issue_valid, wr_en, busy, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_drain_now: got %b want 0000", {issue_valid, wr_en, busy, done});
      end
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_checks++;
         if ({wr_en, busy, done, issue_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_drain_after c%0d: got %b want 0000", c, {wr_en, busy, done, issue_valid});
         end
         step();
      end
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (issue_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_drain_restart: got iv %b busy %b want 1 1", issue_valid, busy);
      end
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      repeat (LAT + 1) step();
   endtask

   task automatic test_start_held();
      int n_first;
      int n_done;
      n_first = 0;
      n_done = 0;
      core_ready = 1'b1;
      abort = 1'b0;
      start = 1'b1;
      for (int c = 0; c <= 22; c++) begin
         @(negedge clk);
         if (c <= 21 && issue_valid && issue_level == '0 && issue_idx == '0) n_first++;
         if (done === 1'b1) n_done++;
         if (c == 20) begin
            n_checks++;
            if (done !== 1'b1) begin
               n_fail++;
               $display("FAIL held_done: got %b want 1", done);
            end
         end
         if (c == 21) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL held_idle: got busy %b want 0", busy);
            end
         end
         if (c == 22) begin
            n_checks++;
            if (issue_valid !== 1'b1 || issue_idx !== '0 || issue_level !== '0) begin
               n_fail++;
               $display("FAIL held_rerun: got iv %b L%0d i%0d want 1 L0 i0", issue_valid, issue_level, issue_idx);
            end
         end
         step();
      end
      n_checks++;
      if (n_first != 1 || n_done != 1) begin
         n_fail++;
         $display("FAIL held_single_run: got starts %0d dones %0d want 1 1", n_first, n_done);
      end
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      repeat (LAT + 1) step();
   endtask

   task automatic test_abort_start_idle();
      core_ready = 1'b1;
      abort = 1'b1;
      start = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_start_idle c%0d: got busy %b iv %b want 0 0", c, busy, issue_valid);
         end
         step();
      end
      abort = 1'b0;
      start = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_ready_gaps();
      test_random();
      test_abort();
      test_reset_drain();
      test_start_held();
      test_abort_start_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
